// File: rtl/pipelined_csel_subtractor_pkg.sv
// Shared constants and result record for the pipelined carry-select subtractor.
// The result struct is also consumed by the ALU flag path.
package pipelined_csel_subtractor_pkg;

  localparam int WIDTH      = 32;
  localparam int BLOCK      = 4;
  localparam int NUM_SLICES = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
  } sub_result_t;

endpackage

// File: rtl/pipelined_csel_subtractor_csel_slice4.sv
// Carry-select slice: both carry-in cases are summed in parallel,
// and the incoming carry only drives the final mux.
module csel_slice4 #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] res_c0;
  logic [BLOCK:0] res_c1;

  assign res_c0 = {1'b0, x} + {1'b0, y};
  assign res_c1 = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, 1'b1};

  assign sum  = cin ? res_c1[BLOCK-1:0] : res_c0[BLOCK-1:0];
  assign cout = cin ? res_c1[BLOCK]     : res_c0[BLOCK];

endmodule

// File: rtl/pipelined_csel_subtractor.sv
// Two-stage a - b (as a + ~b + 1) with a valid/ready handshake on both sides.
// The low half resolves in stage 1; the high half selects on the registered mid carry.
module pipelined_csel_subtractor #(
  parameter int WIDTH = pipelined_csel_subtractor_pkg::WIDTH,
  parameter int BLOCK = pipelined_csel_subtractor_pkg::BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;
  localparam int NH   = HALF / BLOCK;

  logic [WIDTH-1:0] b_n;
  logic [HALF-1:0]  lo_sum;
  logic [HALF-1:0]  hi_sum;

  logic             s1_valid;
  logic [HALF-1:0]  s1_lo_diff;
  logic             s1_mid_c;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_nb_hi;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic             s2_free;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] s2_diff;
  logic             s2_borrow;
  logic             s2_overflow;
  logic             s2_zero;

  assign b_n = ~b;

  // Low half: carry chain starts at 1 (the +1 of two's complement negation).
  for (genvar i = 0; i < NH; i++) begin : g_lo
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_next
      assign cin = g_lo[i-1].cout;
    end
    csel_slice4 #(.BLOCK(BLOCK)) u_slice (
      .x    (a[i*BLOCK +: BLOCK]),
      .y    (b_n[i*BLOCK +: BLOCK]),
      .cin  (cin),
      .sum  (lo_sum[i*BLOCK +: BLOCK]),
      .cout (cout)
    );
  end

  for (genvar i = 0; i < NH; i++) begin : g_hi
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = s1_mid_c;
    end else begin : g_next
      assign cin = g_hi[i-1].cout;
    end
    csel_slice4 #(.BLOCK(BLOCK)) u_slice (
      .x    (s1_a_hi[i*BLOCK +: BLOCK]),
      .y    (s1_nb_hi[i*BLOCK +: BLOCK]),
      .cin  (cin),
      .sum  (hi_sum[i*BLOCK +: BLOCK]),
      .cout (cout)
    );
  end

  assign s2_diff     = {hi_sum, s1_lo_diff};
  assign s2_borrow   = ~g_hi[NH-1].cout;
  assign s2_overflow = (s1_a_msb != s1_b_msb) && (hi_sum[HALF-1] != s1_a_msb);
  assign s2_zero     = (s2_diff == '0);

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign xfer     = s1_valid && s2_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_lo_diff <= '0;
      s1_mid_c   <= 1'b0;
      s1_a_hi    <= '0;
      s1_nb_hi   <= '0;
      s1_a_msb   <= 1'b0;
      s1_b_msb   <= 1'b0;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_lo_diff <= lo_sum;
        s1_mid_c   <= g_lo[NH-1].cout;
        s1_a_hi    <= a[WIDTH-1:HALF];
        s1_nb_hi   <= b_n[WIDTH-1:HALF];
        s1_a_msb   <= a[WIDTH-1];
        s1_b_msb   <= b[WIDTH-1];
      end else if (xfer) begin
        s1_valid <= 1'b0;
      end

      if (xfer) begin
        out_valid <= 1'b1;
        diff      <= s2_diff;
        borrow    <= s2_borrow;
        overflow  <= s2_overflow;
        zero      <= s2_zero;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// Directed and table-driven checks for pipelined_csel_subtractor, with an
// in-order scoreboard on every output handshake.
module tb_pipelined_csel_subtractor;
  import pipelined_csel_subtractor_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  always #5 clk = ~clk;

  pipelined_csel_subtractor #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    sub_result_t      exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          got    = 0;
  sub_result_t exp_q[$];
  sub_result_t sb_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sub_result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    sub_result_t r;
    r.diff     = x - y;
    r.borrow   = (x < y);
    r.overflow = (x[WIDTH-1] != y[WIDTH-1]) && (r.diff[WIDTH-1] != x[WIDTH-1]);
    r.zero     = (r.diff == '0);
    return r;
  endfunction

  // Everything is stable at the falling edge: drive happens 1 time unit after rising.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_diff", {32'd0, diff}, {32'd0, sb_e.diff});
          check("sb_borrow", {63'd0, borrow}, {63'd0, sb_e.borrow});
          check("sb_overflow", {63'd0, overflow}, {63'd0, sb_e.overflow});
          check("sb_zero", {63'd0, zero}, {63'd0, sb_e.zero});
          got++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t             vecs[7];
  logic [WIDTH-1:0] sa[4];
  logic [WIDTH-1:0] sb[4];
  logic [WIDTH-1:0] held;
  int               lat;
  int               n;
  int               k;
  int               got0;

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{32'h0001_0000, 32'h0000_0001, '{32'h0000_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};

    sa[0] = 32'd100;        sb[0] = 32'd1;
    sa[1] = 32'd200;        sb[1] = 32'd2;
    sa[2] = 32'h10;         sb[2] = 32'h20;
    sa[3] = 32'hFFFF_0000;  sb[3] = 32'h0000_FFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff", {32'd0, diff}, 64'd0);
    check("rst_flags", {61'd0, borrow, overflow, zero}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ops from the table: latency and hand-computed results.
    for (int i = 0; i < 7; i++) begin
      a        = vecs[i].a;
      b        = vecs[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      check("vec_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      lat      = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 10);
      check("vec_latency", lat, 2);
      check("vec_diff", {32'd0, diff}, {32'd0, vecs[i].exp.diff});
      check("vec_borrow", {63'd0, borrow}, {63'd0, vecs[i].exp.borrow});
      check("vec_overflow", {63'd0, overflow}, {63'd0, vecs[i].exp.overflow});
      check("vec_zero", {63'd0, zero}, {63'd0, vecs[i].exp.zero});
      @(posedge clk); #1;
    end

    // Back-to-back random stream at full rate.
    got0 = got;
    for (int i = 0; i < 10; i++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_drain_cycles", n, 2);
    check("b2b_results", got - got0, 10);

    // Stall: only two ops fit while the consumer is blocked.
    got0      = got;
    out_ready = 1'b0;
    k         = 0;
    held      = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      a        = sa[k < 4 ? k : 0];
      b        = sb[k < 4 ? k : 0];
      in_valid = (k < 4);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      if (cyc == 2) held = diff;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_accepts", k, 2);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_out_valid", {63'd0, out_valid}, 64'd1);
    check("stall_hold", {32'd0, diff}, {32'd0, held});
    check("stall_first", {32'd0, diff}, {32'd0, model(sa[0], sb[0]).diff});
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while ((k < 4 || exp_q.size() != 0 || out_valid) && n < 20) begin
      a        = sa[k < 4 ? k : 0];
      b        = sb[k < 4 ? k : 0];
      in_valid = (k < 4);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("stall_all_accepted", k, 4);
    check("stall_results", got - got0, 4);

    // Reset with two ops in flight discards both.
    out_ready = 1'b0;
    a = 32'd9;  b = 32'd4;  in_valid = 1'b1;
    @(negedge clk);
    check("rstf_accept0", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    a = 32'd50; b = 32'd8;
    @(negedge clk);
    check("rstf_accept1", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    got0      = got;
    @(negedge clk);
    check("rstf_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstf_diff", {32'd0, diff}, 64'd0);
    check("rstf_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (6) @(negedge clk);
    check("rstf_no_stale", got - got0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
